mem_port_arbiter: RTL and testbench



---
 rtl/arb_types_pkg.sv | 22 ++
 rtl/arb_watchdog.sv | 36 +++
 rtl/mem_port_arbiter.sv | 96 +++++++++
 tb/tb_mem_port_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_types_pkg.sv
// arb_types_pkg: shared types and helpers for the memory port arbiter
package arb_types_pkg;

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} arb_state_t;

    typedef enum logic {PORT_A, PORT_B} port_id_t;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [3:0]  byte_enable;
        logic [31:0] address;
        logic [31:0] wdata;
    } mem_req_t;

    // A request with both strobes high is issued downstream as a write only
    function automatic mem_req_t mk_req(input logic rd, input logic wr, input logic [3:0] be,
                                        input logic [31:0] addr, input logic [31:0] wd);
        return '{read: rd & ~wr, write: wr, byte_enable: be, address: addr, wdata: wd};
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: saturating grant-age counter with a sticky timeout flag
module arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic busy,
    input  logic resp,
    output logic timeout_err
);

    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick = busy & ~resp & (TIMEOUT_CYCLES != 0);

    // Count waiting grant cycles; the flag sets on the edge the count reaches the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (clear)
                cnt <= '0;
            else if (tick && cnt != LIMIT)
                cnt <= cnt + 1'b1;
            if (tick && cnt == LIMIT - 1'b1)
                timeout_err <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction (A) and data (B) requesters
module mem_port_arbiter
    import arb_types_pkg::*;
#(
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmem_read_a,
    input  logic        cmem_write_a,
    input  logic [3:0]  cmem_byte_enable_a,
    input  logic [31:0] cmem_address_a,
    input  logic [31:0] cmem_wdata_a,
    output logic        cmem_resp_a,
    output logic [31:0] cmem_rdata_a,
    input  logic        cmem_read_b,
    input  logic        cmem_write_b,
    input  logic [3:0]  cmem_byte_enable_b,
    input  logic [31:0] cmem_address_b,
    input  logic [31:0] cmem_wdata_b,
    output logic        cmem_resp_b,
    output logic [31:0] cmem_rdata_b,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata,
    output logic        timeout_err
);

    arb_state_t state, next_state;
    port_id_t   last_grant;
    mem_req_t   req_q;
    logic       pend_a, pend_b, pick_b;

    assign pend_a = cmem_read_a | cmem_write_a;
    assign pend_b = cmem_read_b | cmem_write_b;
    assign pick_b = pend_b & (~pend_a | (ARB_MODE == 0) | (last_grant == PORT_A));

    // Arbitrate only from IDLE; a grant ends on the response, forcing one IDLE turnaround
    always_comb begin
        next_state = state;
        if (state == IDLE)
            next_state = pick_b ? GRANT_B : pend_a ? GRANT_A : IDLE;
        else if (mem_resp)
            next_state = IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Latch the winning request on grant entry; drop strobes and record the owner on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= '0;
            last_grant <= PORT_A;
        end else if (state == IDLE && next_state == GRANT_A) begin
            req_q <= mk_req(cmem_read_a, cmem_write_a, cmem_byte_enable_a, cmem_address_a, cmem_wdata_a);
        end else if (state == IDLE && next_state == GRANT_B) begin
            req_q <= mk_req(cmem_read_b, cmem_write_b, cmem_byte_enable_b, cmem_address_b, cmem_wdata_b);
        end else if (state != IDLE && mem_resp) begin
            req_q.read  <= 1'b0;
            req_q.write <= 1'b0;
            last_grant  <= state == GRANT_B ? PORT_B : PORT_A;
        end
    end

    assign mem_read        = req_q.read;
    assign mem_write       = req_q.write;
    assign mem_byte_enable = req_q.byte_enable;
    assign mem_address     = req_q.address;
    assign mem_wdata       = req_q.wdata;

    assign cmem_resp_a  = (state == GRANT_A) & mem_resp;
    assign cmem_resp_b  = (state == GRANT_B) & mem_resp;
    assign cmem_rdata_a = state == GRANT_A ? mem_rdata : '0;
    assign cmem_rdata_b = state == GRANT_B ? mem_rdata : '0;

    arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       ((state == IDLE) & (next_state != IDLE)),
        .busy        (state != IDLE),
        .resp        (mem_resp),
        .timeout_err (timeout_err)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, routing, watchdog and async reset
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        rd_a[2], wr_a[2], rd_b[2], wr_b[2], m_resp[2];
    logic [3:0]  be_a[2], be_b[2];
    logic [31:0] ad_a[2], wd_a[2], ad_b[2], wd_b[2], m_rdata[2];
    logic        rsp_a[2], rsp_b[2], m_rd[2], m_wr[2], terr[2];
    logic [31:0] rdt_a[2], rdt_b[2], m_ad[2], m_wd[2];
    logic [3:0]  m_be[2];

    int n_chk = 0;
    int n_err = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(.ARB_MODE(g), .TIMEOUT_CYCLES(8)) dut (
            .clk                (clk),
            .rst_n              (rst_n),
            .cmem_read_a        (rd_a[g]),
            .cmem_write_a       (wr_a[g]),
            .cmem_byte_enable_a (be_a[g]),
            .cmem_address_a     (ad_a[g]),
            .cmem_wdata_a       (wd_a[g]),
            .cmem_resp_a        (rsp_a[g]),
            .cmem_rdata_a       (rdt_a[g]),
            .cmem_read_b        (rd_b[g]),
            .cmem_write_b       (wr_b[g]),
            .cmem_byte_enable_b (be_b[g]),
            .cmem_address_b     (ad_b[g]),
            .cmem_wdata_b       (wd_b[g]),
            .cmem_resp_b        (rsp_b[g]),
            .cmem_rdata_b       (rdt_b[g]),
            .mem_read           (m_rd[g]),
            .mem_write          (m_wr[g]),
            .mem_byte_enable    (m_be[g]),
            .mem_address        (m_ad[g]),
            .mem_wdata          (m_wd[g]),
            .mem_resp           (m_resp[g]),
            .mem_rdata          (m_rdata[g]),
            .timeout_err        (terr[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic clr(input int u);
        rd_a[u] = 0; wr_a[u] = 0; be_a[u] = 4'hF; ad_a[u] = '0; wd_a[u] = '0;
        rd_b[u] = 0; wr_b[u] = 0; be_b[u] = 4'hF; ad_b[u] = '0; wd_b[u] = '0;
        m_resp[u] = 0; m_rdata[u] = '0;
    endtask

    initial begin
        clr(0);
        clr(1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        smp;
        for (int u = 0; u < 2; u++) begin
            chk("rst_rd", m_rd[u], 0);
            chk("rst_wr", m_wr[u], 0);
            chk("rst_be", m_be[u], 0);
            chk("rst_addr", m_ad[u], 0);
            chk("rst_wdata", m_wd[u], 0);
            chk("rst_resp_a", rsp_a[u], 0);
            chk("rst_resp_b", rsp_b[u], 0);
            chk("rst_terr", terr[u], 0);
        end

        step; m_resp[0] = 1; m_rdata[0] = 32'hAAAA5555;
        smp;
        chk("idle_resp_a", rsp_a[0], 0);
        chk("idle_resp_b", rsp_b[0], 0);
        chk("idle_rdata_a", rdt_a[0], 0);
        step; m_resp[0] = 0;

        step; rd_a[0] = 1; ad_a[0] = 32'h100;
        smp;
        chk("a_rd_latency", m_rd[0], 0);
        step;
        smp;
        chk("a_rd_strobe", m_rd[0], 1);
        chk("a_rd_addr", m_ad[0], 32'h100);
        step; step; step; m_resp[0] = 1; m_rdata[0] = 32'hDEADBEEF;
        smp;
        chk("a_resp", rsp_a[0], 1);
        chk("a_rdata", rdt_a[0], 32'hDEADBEEF);
        chk("a_resp_b_quiet", rsp_b[0], 0);
        chk("a_rdata_b_zero", rdt_b[0], 0);
        step; clr(0);
        smp;
        chk("a_done_rd", m_rd[0], 0);
        chk("a_done_resp", rsp_a[0], 0);

        step;
        rd_a[0] = 1; ad_a[0] = 32'h40;
        wr_b[0] = 1; ad_b[0] = 32'h80; wd_b[0] = 32'h12345678; be_b[0] = 4'b0011;
        step;
        smp;
        chk("fix_b_wr", m_wr[0], 1);
        chk("fix_b_rd", m_rd[0], 0);
        chk("fix_b_addr", m_ad[0], 32'h80);
        chk("fix_b_be", m_be[0], 4'b0011);
        chk("fix_b_wdata", m_wd[0], 32'h12345678);
        step; m_resp[0] = 1;
        smp;
        chk("fix_b_resp", rsp_b[0], 1);
        chk("fix_b_resp_a_quiet", rsp_a[0], 0);
        step; m_resp[0] = 0; wr_b[0] = 0;
        smp;
        chk("fix_turn_rd", m_rd[0], 0);
        chk("fix_turn_wr", m_wr[0], 0);
        step;
        smp;
        chk("fix_a_rd", m_rd[0], 1);
        chk("fix_a_addr", m_ad[0], 32'h40);
        step; m_resp[0] = 1;
        smp;
        chk("fix_a_resp", rsp_a[0], 1);
        step; clr(0);

        for (int r = 0; r < 4; r++) begin
            step;
            rd_a[1] = 1; ad_a[1] = 32'h40;
            wr_b[1] = 1; ad_b[1] = 32'h80; wd_b[1] = 32'h12345678; be_b[1] = 4'b0011;
            step;
            smp;
            chk($sformatf("rr_addr%0d", r), m_ad[1], (r % 2 == 0) ? 32'h80 : 32'h40);
            step; m_resp[1] = 1;
            smp;
            chk($sformatf("rr_resp_b%0d", r), rsp_b[1], (r % 2 == 0) ? 1 : 0);
            step; clr(1);
        end

        step; rd_b[0] = 1; wr_b[0] = 1; ad_b[0] = 32'h200;
        step;
        smp;
        chk("rw_wr", m_wr[0], 1);
        chk("rw_rd", m_rd[0], 0);
        step; m_resp[0] = 1;
        step; clr(0);

        step; rd_a[0] = 1; ad_a[0] = 32'h300;
        step;
        repeat (7) step;
        smp;
        chk("wd_before", terr[0], 0);
        step;
        smp;
        chk("wd_at_8", terr[0], 1);
        step; m_resp[0] = 1; m_rdata[0] = 32'h0BADF00D;
        smp;
        chk("wd_late_resp", rsp_a[0], 1);
        chk("wd_late_rdata", rdt_a[0], 32'h0BADF00D);
        step; clr(0);
        smp;
        chk("wd_done_rd", m_rd[0], 0);
        chk("wd_sticky", terr[0], 1);

        step; rd_a[0] = 1; ad_a[0] = 32'h400;
        step;
        smp;
        chk("rs_granted", m_rd[0], 1);
        m_resp[0] = 1;
        #1;
        chk("rs_resp_live", rsp_a[0], 1);
        rst_n = 1'b0;
        #1;
        chk("rs_rd_drop", m_rd[0], 0);
        chk("rs_resp_drop", rsp_a[0], 0);
        chk("rs_addr_drop", m_ad[0], 0);
        chk("rs_terr_drop", terr[0], 0);
        m_resp[0] = 0;
        #2 rst_n = 1'b1;
        step;
        smp;
        chk("rs_regrant_rd", m_rd[0], 1);
        chk("rs_regrant_addr", m_ad[0], 32'h400);
        step; m_resp[0] = 1;
        smp;
        chk("rs_regrant_resp", rsp_a[0], 1);
        step; clr(0);
        smp;
        chk("rs_done_rd", m_rd[0], 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
